filter_sched: RTL and testbench

FILTER_SCHED -- requirements
Module: filter_sched

---
 rtl/filter_sched.sv | 166 ++++++++++++++++
 tb/tb_filter_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sched.sv
// Frame scheduler for a line-buffered filter: primes on the first lines, runs, drains, and
// applies kernel changes only at frame start. Optional macro FILTER_SCHED_STATS_EN adds a resync counter.
module filter_sched #(
    parameter int H_LAST       = 1279,
    parameter int V_LAST       = 719,
    parameter int PRIME_LINES  = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [2:0]  sel_req_in,
    input  logic        sel_req_valid_in,
    output logic [2:0]  k_select_out,
    output logic        pipe_en_out,
    output logic        frame_start_out,
    output logic        frame_done_out,
    output logic        sync_err_out,
    output logic [7:0]  frame_count_out,
    output logic [7:0]  sync_err_count_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [10:0] H_LAST_V   = 11'(H_LAST);
    localparam logic [9:0]  V_LAST_V   = 10'(V_LAST);
    localparam logic [15:0] PRIME_LAST = 16'(PRIME_LINES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t      state_q;
    logic [15:0] line_cnt_q;
    logic [15:0] drain_cnt_q;
    logic [2:0]  pend_q;
    logic [2:0]  pend_d;
    logic [2:0]  k_sel_q;
    logic        frame_start_q;
    logic        frame_done_q;
    logic        sync_err_q;
    logic [7:0]  frame_cnt_q;

    logic fs_ev;
    logic le_ev;
    logic fe_ev;
    logic done_d;
    logic resync_d;

    // Stream events; counts are meaningless unless data_valid_in is high.
    always_comb begin
        fs_ev = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        le_ev = data_valid_in && (hcount_in == H_LAST_V);
        fe_ev = le_ev && (vcount_in == V_LAST_V);
    end

    always_comb begin
        pend_d = sel_req_valid_in ? sel_req_in : pend_q;
    end

    // drain_cnt_q counts remaining DRAIN cycles down to 0; the done pulse is registered so
    // it lands on the last DRAIN cycle. An FS arriving on that cycle must not count twice.
    always_comb begin
        resync_d = fs_ev && ((state_q == PRIME) || (state_q == RUN));
        done_d   = 1'b0;
        case (state_q)
            RUN:     done_d = !fs_ev && fe_ev && (DRAIN_LAST == 16'd0);
            DRAIN:   done_d = fs_ev ? (drain_cnt_q != 16'd0) : (drain_cnt_q == 16'd1);
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            line_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            pend_q        <= '0;
            k_sel_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            pend_q        <= pend_d;
            frame_start_q <= fs_ev;
            frame_done_q  <= done_d;
            sync_err_q    <= resync_d;
            if (fs_ev) begin
                k_sel_q <= pend_d;
            end
            if (done_d) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (fs_ev) begin
                        state_q    <= PRIME;
                        line_cnt_q <= '0;
                    end
                end
                PRIME: begin
                    if (fs_ev) begin
                        line_cnt_q <= '0;
                    end else if (le_ev) begin
                        line_cnt_q <= line_cnt_q + 16'd1;
                        if (line_cnt_q == PRIME_LAST) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fs_ev) begin
                        state_q    <= PRIME;
                        line_cnt_q <= '0;
                    end else if (fe_ev) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= DRAIN_LAST;
                    end
                end
                DRAIN: begin
                    if (fs_ev) begin
                        state_q    <= PRIME;
                        line_cnt_q <= '0;
                    end else if (drain_cnt_q == 16'd0) begin
                        state_q <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FILTER_SCHED_STATS_EN
    logic [7:0] sync_err_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_err_cnt_q <= '0;
        end else if (resync_d && (sync_err_cnt_q != 8'hFF)) begin
            sync_err_cnt_q <= sync_err_cnt_q + 8'd1;
        end
    end

    assign sync_err_count_out = sync_err_cnt_q;
`else
    assign sync_err_count_out = 8'd0;
`endif

    // RUN and DRAIN are the only encodings with bit 1 set, so this is a plain register bit.
    assign pipe_en_out     = state_q[1];
    assign k_select_out    = k_sel_q;
    assign frame_start_out = frame_start_q;
    assign frame_done_out  = frame_done_q;
    assign sync_err_out    = sync_err_q;
    assign frame_count_out = frame_cnt_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_filter_sched.sv
// Bench for filter_sched: directed frame scenarios plus random streams, every cycle compared
// against an event-level reference model of the scheduler.
module tb_filter_sched;

    localparam int HL = 1;
    localparam int VL = 127;
    localparam int PL = 2;
    localparam int DC = 4;
    localparam int LAST_IDX = (VL + 1) * (HL + 1) - 1;
`ifdef FILTER_SCHED_STATS_EN
    localparam logic [7:0] SE_EXP = 8'd1;
`else
    localparam logic [7:0] SE_EXP = 8'd0;
`endif

    logic        clk;
    logic        rst;
    logic        dv;
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  sel;
    logic        selv;
    logic [2:0]  k_select;
    logic        pipe_en;
    logic        fstart;
    logic        fdone;
    logic        serr;
    logic [7:0]  fcount;
    logic [7:0]  secount;
    logic [1:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int m_state, m_lines, m_age, m_pend, m_ksel, m_fcnt, m_secnt;
    bit m_fs, m_fd, m_se;

    filter_sched #(
        .H_LAST(HL), .V_LAST(VL), .PRIME_LINES(PL), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_in(clk), .rst_in(rst), .data_valid_in(dv), .hcount_in(h), .vcount_in(v),
        .sel_req_in(sel), .sel_req_valid_in(selv), .k_select_out(k_select),
        .pipe_en_out(pipe_en), .frame_start_out(fstart), .frame_done_out(fdone),
        .sync_err_out(serr), .frame_count_out(fcount), .sync_err_count_out(secount),
        .state_out(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_done();
        m_fd = 1'b1;
        m_fcnt = (m_fcnt + 1) % 256;
    endtask

    task automatic model_edge(input logic r, input logic d, input logic [10:0] hh,
                              input logic [9:0] vv, input logic sv, input logic [2:0] s);
        bit fs_e, le_e, fe_e;
        if (r) begin
            m_state = 0; m_lines = 0; m_age = 0; m_pend = 0; m_ksel = 0;
            m_fcnt = 0; m_secnt = 0; m_fs = 0; m_fd = 0; m_se = 0;
            return;
        end
        fs_e = d && (hh == 0) && (vv == 0);
        le_e = d && (int'(hh) == HL);
        fe_e = le_e && (int'(vv) == VL);
        m_fs = 0; m_fd = 0; m_se = 0;
        if (sv) m_pend = s;
        if (fs_e) m_ksel = m_pend;
        case (m_state)
            0: if (fs_e) begin m_state = 1; m_lines = 0; m_fs = 1; end
            1, 2: begin
                if (fs_e) begin
                    m_se = 1; m_fs = 1; m_state = 1; m_lines = 0;
`ifdef FILTER_SCHED_STATS_EN
                    if (m_secnt < 255) m_secnt++;
`endif
                end else if (m_state == 1 && le_e) begin
                    m_lines++;
                    if (m_lines == PL) m_state = 2;
                end else if (m_state == 2 && fe_e) begin
                    m_state = 3; m_age = 1;
                    if (DC == 1) model_done();
                end
            end
            default: begin
                if (fs_e) begin
                    if (m_age < DC) model_done();
                    m_fs = 1; m_state = 1; m_lines = 0;
                end else if (m_age == DC) begin
                    m_state = 0;
                end else begin
                    m_age++;
                    if (m_age == DC) model_done();
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("k_select", 8'(k_select), 8'(m_ksel));
        chk("pipe_en", 8'(pipe_en), 8'(m_state >= 2));
        chk("frame_start", 8'(fstart), 8'(m_fs));
        chk("frame_done", 8'(fdone), 8'(m_fd));
        chk("sync_err", 8'(serr), 8'(m_se));
        chk("frame_count", fcount, 8'(m_fcnt));
        chk("sync_err_count", secount, 8'(m_secnt));
        chk("state", 8'(state), 8'(m_state));
    endtask

    task automatic step(input logic r, input logic d, input logic [10:0] hh,
                        input logic [9:0] vv, input logic sv, input logic [2:0] s);
        rst = r; dv = d; h = hh; v = vv; selv = sv; sel = s;
        @(posedge clk);
        model_edge(r, d, hh, vv, sv, s);
        #1;
        check_all();
    endtask

    // dv=0 with counts that would look like FS/LE if they were honoured
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 11'($urandom_range(0, 1)), 10'($urandom_range(0, 1) * VL), 1'b0, 3'd0);
    endtask

    task automatic req(input logic [2:0] s);
        step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, s);
    endtask

    task automatic run_px(input int a, input int b, input bit gaps, input bit rsel);
        for (int i = a; i <= b; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            if (rsel && $urandom_range(0, 7) == 0) req(3'($urandom_range(0, 7)));
            step(1'b0, 1'b1, 11'(i % (HL + 1)), 10'(i / (HL + 1)), 1'b0, 3'd0);
        end
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; h = '0; v = '0; sel = '0; selv = 1'b0;

        // Reset
        step(1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 11'd0, 10'd0, 1'b1, 3'd4);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_k_select", 8'(k_select), 8'd0);
        chk("rst_frame_count", fcount, 8'd0);
        idle(2);

        // One clean frame: pipe enables after the second line end, done DC cycles after FE
        run_px(0, 2, 1'b0, 1'b0);
        chk("pipe_en_before_le2", 8'(pipe_en), 8'd0);
        run_px(3, 3, 1'b0, 1'b0);
        chk("pipe_en_after_le2", 8'(pipe_en), 8'd1);
        run_px(4, LAST_IDX, 1'b0, 1'b0);
        idle(DC - 1);
        chk("done_at_fe_plus_dc", 8'(fdone), 8'd1);
        chk("frame_count_1", fcount, 8'd1);
        idle(1);
        chk("idle_after_drain", 8'(state), 8'd0);
        chk("done_single_pulse", 8'(fdone), 8'd0);

        // Mid-frame request applies only at the next FS
        idle(2);
        run_px(0, 50, 1'b1, 1'b0);
        req(3'd5);
        run_px(51, LAST_IDX, 1'b1, 1'b0);
        idle(DC + 2);
        chk("k_held_until_fs", 8'(k_select), 8'd0);
        run_px(0, 0, 1'b0, 1'b0);
        chk("k_after_fs_5", 8'(k_select), 8'd5);

        // Last request wins, and a same-cycle request on FS overrides the pending one
        run_px(1, 80, 1'b1, 1'b0);
        req(3'd3);
        run_px(81, 150, 1'b1, 1'b0);
        req(3'd6);
        run_px(151, LAST_IDX, 1'b1, 1'b0);
        idle(DC + 2);
        chk("k_held_6_pending", 8'(k_select), 8'd5);
        step(1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 3'd2);
        chk("k_same_cycle_2", 8'(k_select), 8'd2);

        // FS while in RUN at line 100 is a resync
        run_px(1, 100 * (HL + 1) - 1, 1'b1, 1'b1);
        chk("run_before_resync", 8'(state), 8'd2);
        step(1'b0, 1'b1, 11'd0, 10'd0, 1'b0, 3'd0);
        chk("resync_sync_err", 8'(serr), 8'd1);
        chk("resync_state_prime", 8'(state), 8'd1);
        chk("resync_pipe_off", 8'(pipe_en), 8'd0);
        chk("resync_fcount_held", fcount, 8'd3);
        chk("resync_no_done", 8'(fdone), 8'd0);
        chk("resync_err_count", secount, SE_EXP);
        idle(1);
        chk("sync_err_one_pulse", 8'(serr), 8'd0);

        // FS two cycles after FE ends the old frame and starts the new one together
        run_px(1, LAST_IDX, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 11'd0, 10'd0, 1'b0, 3'd0);
        chk("drain_fs_done", 8'(fdone), 8'd1);
        chk("drain_fs_start", 8'(fstart), 8'd1);
        chk("drain_fs_state", 8'(state), 8'd1);
        chk("drain_fs_fcount", fcount, 8'd4);

        // Reset mid-RUN wins over FS and a request in the same cycle
        run_px(1, 10 * (HL + 1) + 1, 1'b1, 1'b0);
        chk("mid_run_state", 8'(state), 8'd2);
        step(1'b1, 1'b1, 11'd0, 10'd0, 1'b1, 3'd7);
        chk("mid_rst_state", 8'(state), 8'd0);
        chk("mid_rst_pipe", 8'(pipe_en), 8'd0);
        chk("mid_rst_k", 8'(k_select), 8'd0);
        chk("mid_rst_start", 8'(fstart), 8'd0);
        chk("mid_rst_done", 8'(fdone), 8'd0);
        chk("mid_rst_fcount", fcount, 8'd0);
        chk("mid_rst_secount", secount, 8'd0);
        idle(2);

        // 256 frames wrap the frame counter
        for (int f = 0; f < 255; f++) begin
            run_px(0, LAST_IDX, 1'b0, 1'b0);
            idle(DC + 1);
        end
        chk("frame_count_255", fcount, 8'd255);
        run_px(0, LAST_IDX, 1'b0, 1'b0);
        idle(DC + 1);
        chk("frame_count_wrap", fcount, 8'd0);

        // Random stream: frame-start, line-end and frame-end events in arbitrary order
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] rv;
            case ($urandom_range(0, 3))
                0: rv = 10'd0;
                1: rv = 10'(VL);
                default: rv = 10'($urandom_range(0, VL));
            endcase
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
                 11'($urandom_range(0, HL)), rv,
                 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
